// File: rtl/mem_responder.sv
// mem_responder: MAR/MDR memory-port responder.
// Accepts one read/write request at a time, waits LATENCY cycles, performs the
// access on an internal 32-bit word array and returns a one-cycle ack.
// Optional feature macro: MEM_WP_EN (write-protects words 0..WP_LIMIT-1).
module mem_responder #(
  parameter int ADDR_W   = 9,
  parameter int DEPTH    = 512,
  parameter int LATENCY  = 2,
  parameter int WP_LIMIT = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ack_q, ack_d;
  logic              busy_q, busy_d;
  logic              err_q, err_d;

  logic [31:0]       mem_q [DEPTH];
  logic [IDX_W-1:0]  idx_s;
  logic [31:0]       rd_word_s;
  logic              in_range_s;
  logic              wp_hit_s;
  logic              mem_we_s;

  // Only the low index bits address the array; out-of-range addresses are
  // filtered by in_range_s before any access happens.
  assign idx_s      = addr_q[IDX_W-1:0];
  assign in_range_s = (32'(addr_q) < 32'(DEPTH));
  assign rd_word_s  = mem_q[idx_s];

`ifdef MEM_WP_EN
  assign wp_hit_s = (32'(addr_q) < 32'(WP_LIMIT));
`else
  logic wp_unused_s;
  assign wp_hit_s    = 1'b0;
  assign wp_unused_s = (WP_LIMIT != 0);
`endif

  // Next-state and output decode for the IDLE/WAIT/RESP handshake.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    ack_d    = ack_q;
    busy_d   = busy_q;
    err_d    = err_q;
    mem_we_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        ack_d = 1'b0;
        err_d = 1'b0;
        if (req) begin
          state_d = ST_WAIT;
          cnt_d   = 4'(LATENCY);
          we_d    = we;
          addr_d  = addr;
          wdata_d = wdata;
          busy_d  = 1'b1;
        end else begin
          busy_d  = 1'b0;
        end
      end

      ST_WAIT: begin
        busy_d = 1'b1;
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          ack_d   = 1'b1;
          state_d = ST_RESP;
          if (!in_range_s) begin
            // Out-of-range: reads return zero, writes are dropped.
            err_d = 1'b1;
            if (!we_q) begin
              rdata_d = 32'd0;
            end else begin
              rdata_d = rdata_q;
            end
          end else if (we_q) begin
            if (wp_hit_s) begin
              err_d = 1'b1;
            end else begin
              err_d    = 1'b0;
              mem_we_s = 1'b1;
            end
          end else begin
            rdata_d = rd_word_s;
            err_d   = 1'b0;
          end
        end
      end

      ST_RESP: begin
        // Leaving RESP straight to IDLE keeps a held req from being
        // accepted on this edge.
        ack_d   = 1'b0;
        err_d   = 1'b0;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = 4'd0;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Control and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Word array write port; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      mem_q[idx_s] <= wdata_q;
    end
  end

  assign rdata = rdata_q;
  assign ack   = ack_q;
  assign busy  = busy_q;
  assign err   = err_q;

endmodule
